// File: rtl/aes128_encrypt_core_if.sv
// Load strobe, block inputs and registered result of aes128_encrypt_core.
// The `done` flag exists only when ENCRYPT_DONE_EN is defined.
interface aes128_encrypt_core_if;
   logic         enable;
   logic [0:127] plaintext;
   logic [0:127] key;
   logic [0:127] ciphertext;
`ifdef ENCRYPT_DONE_EN
   logic         done;

   modport master (output enable, plaintext, key, input ciphertext, done);
   modport slave  (input enable, plaintext, key, output ciphertext, done);
`else
   modport master (output enable, plaintext, key, input ciphertext);
   modport slave  (input enable, plaintext, key, output ciphertext);
`endif
endinterface

// File: rtl/aes128_encrypt_core.sv
// Iterative AES-128 encryptor: one round per clock, on-the-fly key expansion.
// Define ENCRYPT_DONE_EN to add the `done` completion flag.
module aes128_encrypt_core (
   input logic                  clk,
   input logic                  reset,
   aes128_encrypt_core_if.slave bus
);
   localparam logic [0:2047] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[{b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   typedef enum logic {IDLE, BUSY} fsm_e;

   fsm_e         fsm_q, fsm_d;
   logic [127:0] state_q, state_d;
   logic [127:0] rkey_q, rkey_d;
   logic [127:0] ct_q, ct_d;
   logic [3:0]   round_q, round_d;

   logic [127:0] sub_bytes, shift_rows, mix_cols, rkey_next, round_out;
   logic [7:0]   rcon;
   logic         last_round;

   assign last_round = (round_q == 4'd10);

   // Internal vectors keep byte n at [127-8n -: 8], same order as the [0:127] ports.
   genvar gi;
   for (gi = 0; gi < 16; gi++) begin : g_sub_shift
      localparam int COL = gi / 4;
      localparam int ROW = gi % 4;
      localparam int SRC = 4 * ((COL + ROW) % 4) + ROW;
      assign sub_bytes[127-8*gi -: 8]  = sbox(state_q[127-8*gi -: 8]);
      assign shift_rows[127-8*gi -: 8] = sub_bytes[127-8*SRC -: 8];
   end

   for (gi = 0; gi < 4; gi++) begin : g_mix
      logic [7:0] a0, a1, a2, a3;
      assign {a0, a1, a2, a3} = shift_rows[127-32*gi -: 32];
      assign mix_cols[127-32*gi -: 32] = last_round ? {a0, a1, a2, a3} :
         {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
          a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
          a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
          xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   end

   always_comb begin
      rcon = 8'h00;
      case (round_q)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   end

   logic [31:0] w0, w1, w2, w3, temp, nw0, nw1, nw2, nw3;
   assign {w0, w1, w2, w3} = rkey_q;
   assign temp = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
   assign nw0 = w0 ^ temp;
   assign nw1 = w1 ^ nw0;
   assign nw2 = w2 ^ nw1;
   assign nw3 = w3 ^ nw2;
   assign rkey_next = {nw0, nw1, nw2, nw3};
   assign round_out = mix_cols ^ rkey_next;

   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      rkey_d  = rkey_q;
      round_d = round_q;
      ct_d    = ct_q;
      if (bus.enable) begin
         state_d = bus.plaintext ^ bus.key;
         rkey_d  = bus.key;
         round_d = 4'd1;
         fsm_d   = BUSY;
      end else if (fsm_q == BUSY) begin
         state_d = round_out;
         rkey_d  = rkey_next;
         if (last_round) begin
            ct_d    = round_out;
            round_d = 4'd0;
            fsm_d   = IDLE;
         end else begin
            round_d = round_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fsm_q   <= IDLE;
         state_q <= '0;
         rkey_q  <= '0;
         ct_q    <= '0;
         round_q <= '0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         rkey_q  <= rkey_d;
         ct_q    <= ct_d;
         round_q <= round_d;
      end
   end

   assign bus.ciphertext = ct_q;

`ifdef ENCRYPT_DONE_EN
   logic done_q, done_d;

   always_comb begin
      done_d = done_q;
      if (bus.enable)
         done_d = 1'b0;
      else if (fsm_q == BUSY && last_round)
         done_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         done_q <= 1'b0;
      else
         done_q <= done_d;
   end

   assign bus.done = done_q;
`endif
endmodule

// File: tb/tb_aes128_encrypt_core.sv
// Self-checking bench for aes128_encrypt_core: FIPS-197 vectors, reset/abort cases
// and random blocks against an array-based AES model with a GF(2^8)-derived S-box.
module tb_aes128_encrypt_core;
   logic clk;
   logic reset_n;
   int   checks;
   int   failures;

   aes128_encrypt_core_if bus ();

   aes128_encrypt_core dut (
      .clk   (clk),
      .reset (reset_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   logic [7:0] sbox_m [256];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   // Full key schedule up front, then ten textbook rounds on a byte array.
   function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   k [176];
      logic [7:0]   w [4];
      logic [7:0]   rc = 8'h01;
      logic [127:0] res;
      for (int i = 0; i < 16; i++) begin
         s[i] = pt[127-8*i -: 8];
         k[i] = key[127-8*i -: 8];
      end
      for (int i = 16; i < 176; i += 4) begin
         for (int j = 0; j < 4; j++) w[j] = k[i-4+j];
         if (i % 16 == 0) begin
            logic [7:0] first = w[0];
            w[0] = sbox_m[w[1]] ^ rc;
            w[1] = sbox_m[w[2]];
            w[2] = sbox_m[w[3]];
            w[3] = sbox_m[first];
            rc   = gmul(rc, 8'h02);
         end
         for (int j = 0; j < 4; j++) k[i+j] = k[i-16+j] ^ w[j];
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
      for (int r = 1; r <= 10; r++) begin
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
               t[4*c+row] = sbox_m[s[4*((c+row)%4)+row]];
         for (int c = 0; c < 4; c++) begin
            if (r < 10) begin
               s[4*c+0] = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
               s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
               s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
               s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
            end else begin
               for (int row = 0; row < 4; row++) s[4*c+row] = t[4*c+row];
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[16*r+i];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_done(input string tag, input logic exp);
`ifdef ENCRYPT_DONE_EN
      check_eq(tag, {127'd0, bus.done}, {127'd0, exp});
`else
      if (exp === 1'bx) $display("unreachable %s", tag);
`endif
   endtask

   // One load edge, then nine cycles where the old result must hold, then the new one.
   task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] key,
                            input logic [127:0] exp, input logic [127:0] prev, input logic scramble);
      bus.enable    = 1'b1;
      bus.plaintext = pt;
      bus.key       = key;
      tick();
      bus.enable = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         if (scramble) begin
            bus.plaintext = {$urandom, $urandom, $urandom, $urandom};
            bus.key       = {$urandom, $urandom, $urandom, $urandom};
         end
         tick();
         if (c == 5 || c == 9) begin
            check_eq({tag, "_hold"}, bus.ciphertext, prev);
            check_done({tag, "_busy_done"}, 1'b0);
         end
      end
      tick();
      check_eq(tag, bus.ciphertext, exp);
      check_done({tag, "_done"}, 1'b1);
      $display("block %s pt=%h key=%h ct=%h", tag, pt, key, bus.ciphertext);
   endtask

   logic [127:0] prev_ct;

   initial begin
      checks        = 0;
      failures      = 0;
      reset_n       = 1'b0;
      bus.enable    = 1'b0;
      bus.plaintext = '0;
      bus.key       = '0;
      build_sbox();
      #12;
      check_eq("reset_ct", bus.ciphertext, 128'h0);
      check_done("reset_done", 1'b0);
      tick();
      reset_n = 1'b1;
      tick();

      // C.1 with enable held two cycles
      bus.enable    = 1'b1;
      bus.plaintext = PT_C1;
      bus.key       = KEY_C1;
      tick();
      tick();
      bus.enable = 1'b0;
      for (int c = 0; c < 12; c++) tick();
      check_eq("c1_hold2", bus.ciphertext, CT_C1);
      $display("block c1 ct=%h", bus.ciphertext);

      run_block("fips_b", PT_B, KEY_B, CT_B, CT_C1, 1'b1);
      tick();
      run_block("zeros", '0, '0, CT_Z, CT_B, 1'b0);
      tick();
      run_block("c1_after_zeros", PT_C1, KEY_C1, CT_C1, CT_Z, 1'b0);

      // asynchronous reset mid-run
      bus.enable    = 1'b1;
      bus.plaintext = PT_B;
      bus.key       = KEY_B;
      tick();
      bus.enable = 1'b0;
      for (int c = 0; c < 5; c++) tick();
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("async_reset_ct", bus.ciphertext, 128'h0);
      check_done("async_reset_done", 1'b0);
      tick();
      tick();
      reset_n = 1'b1;
      for (int c = 0; c < 12; c++) tick();
      check_eq("no_stale_after_reset", bus.ciphertext, 128'h0);
      check_done("no_stale_done", 1'b0);
      $display("block reset_abort ct=%h", bus.ciphertext);

      // abort at round 4 and reload with vector B
      bus.enable    = 1'b1;
      bus.plaintext = PT_C1;
      bus.key       = KEY_C1;
      tick();
      bus.enable = 1'b0;
      for (int c = 0; c < 4; c++) tick();
      run_block("abort_reload_b", PT_B, KEY_B, CT_B, 128'h0, 1'b0);

      // back-to-back, one-cycle pulse every 12 cycles
      prev_ct = CT_B;
      run_block("b2b_c1", PT_C1, KEY_C1, CT_C1, prev_ct, 1'b0);
      tick();
      run_block("b2b_b", PT_B, KEY_B, CT_B, CT_C1, 1'b0);
      tick();
      run_block("b2b_zeros", '0, '0, CT_Z, CT_B, 1'b0);
      tick();
      prev_ct = CT_Z;

      for (int n = 0; n < 16; n++) begin
         logic [127:0] pt, key, exp;
         int           gap;
         pt  = {$urandom, $urandom, $urandom, $urandom};
         key = {$urandom, $urandom, $urandom, $urandom};
         exp = aes_ref(pt, key);
         run_block($sformatf("rand%0d", n), pt, key, exp, prev_ct, 1'b1);
         gap = $urandom_range(1, 4);
         for (int c = 0; c < gap; c++) tick();
         check_eq($sformatf("rand%0d_idle_hold", n), bus.ciphertext, exp);
         prev_ct = exp;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
